// File: rtl/mux_arb_rr.sv
`default_nettype none
// ============================================================================
//  Module   : mux_arb_rr
//  Brief    : N-channel registered mux with valid/ready handshake, fixed-select
//             or round-robin arbitration among valid producers.
//  Revision : 1.0  initial release
// ============================================================================
module mux_arb_rr #(
  parameter  int ANCHO     = 8,
  parameter  int N_CANALES = 4,
  localparam int SW        = $clog2(N_CANALES)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [N_CANALES*ANCHO-1:0] d,
  input  logic [N_CANALES-1:0]       valid_i,
  output logic [N_CANALES-1:0]       ready_o,
  input  logic                       modo,
  input  logic [SW-1:0]              sel,
  output logic [ANCHO-1:0]           q,
  output logic [SW-1:0]              canal_o,
  output logic                       valid_o,
  input  logic                       ready_i
);

  localparam logic [SW:0]   C_N    = (SW+1)'(N_CANALES);
  localparam logic [SW-1:0] C_LAST = SW'(N_CANALES - 1);

  logic [ANCHO-1:0]     r_q;
  logic [SW-1:0]        r_canal;
  logic                 r_valid;
  logic [SW-1:0]        r_ptr;

  logic                 w_carga;
  logic [N_CANALES-1:0] w_grant;
  logic [SW-1:0]        w_gidx;
  logic                 w_hit;
  logic [SW:0]          w_pos;
  logic [ANCHO-1:0]     w_dmux;

  // Output register is free when empty or being drained this cycle.
  assign w_carga = !r_valid || ready_i;

  always_comb begin
    w_grant = '0;
    w_gidx  = '0;
    w_hit   = 1'b0;
    w_pos   = '0;
    if (!modo) begin
      for (int k = 0; k < N_CANALES; k++) begin
        if (sel == SW'(k) && valid_i[k]) begin
          w_grant[k] = 1'b1;
          w_gidx     = SW'(k);
          w_hit      = 1'b1;
        end
      end
    end else begin
      // Scan ptr, ptr+1, ... modulo N_CANALES; first valid channel wins.
      for (int i = 0; i < N_CANALES; i++) begin
        w_pos = {1'b0, r_ptr} + (SW+1)'(i);
        if (w_pos >= C_N) begin
          w_pos = w_pos - C_N;
        end
        if (!w_hit && valid_i[w_pos[SW-1:0]]) begin
          w_grant[w_pos[SW-1:0]] = 1'b1;
          w_gidx                 = w_pos[SW-1:0];
          w_hit                  = 1'b1;
        end
      end
    end
  end

  always_comb begin
    w_dmux = '0;
    for (int k = 0; k < N_CANALES; k++) begin
      if (w_grant[k]) begin
        w_dmux = d[k*ANCHO +: ANCHO];
      end
    end
  end

  // Gated by rst_n so no producer sees a handshake while reset is held.
  assign ready_o = (rst_n && w_carga) ? w_grant : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q     <= '0;
      r_canal <= '0;
      r_valid <= 1'b0;
      r_ptr   <= '0;
    end else if (w_carga) begin
      if (w_hit) begin
        r_q     <= w_dmux;
        r_canal <= w_gidx;
        r_valid <= 1'b1;
        if (modo) begin
          r_ptr <= (w_gidx == C_LAST) ? '0 : w_gidx + SW'(1);
        end
      end else begin
        r_valid <= 1'b0;
      end
    end
  end

  assign q       = r_q;
  assign canal_o = r_canal;
  assign valid_o = r_valid;

endmodule
`default_nettype wire

// File: tb/tb_mux_arb_rr.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mux_arb_rr
//  Brief    : Directed, table-driven bench for mux_arb_rr (ANCHO=8, N=4).
//  Revision : 1.0  initial release
// ============================================================================
module tb_mux_arb_rr;

  localparam int ANCHO = 8;
  localparam int N     = 4;
  localparam int SW    = 2;

  logic               clk = 1'b0;
  logic               rst_n;
  logic [N*ANCHO-1:0] d;
  logic [N-1:0]       valid_i;
  logic [N-1:0]       ready_o;
  logic               modo;
  logic [SW-1:0]      sel;
  logic [ANCHO-1:0]   q;
  logic [SW-1:0]      canal_o;
  logic               valid_o;
  logic               ready_i;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic        modo;
    logic [1:0]  sel;
    logic [3:0]  vin;
    logic [31:0] dd;
    logic        rdy;
    logic [3:0]  exp_ro;
    logic [7:0]  exp_q;
    logic [1:0]  exp_c;
    logic        exp_v;
  } vec_t;

  vec_t vecs[23];

  mux_arb_rr #(.ANCHO(ANCHO), .N_CANALES(N)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .d       (d),
    .valid_i (valid_i),
    .ready_o (ready_o),
    .modo    (modo),
    .sel     (sel),
    .q       (q),
    .canal_o (canal_o),
    .valid_o (valid_o),
    .ready_i (ready_i)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Entered just after a rising edge; ends just after the following one.
  task automatic apply_vec(input vec_t v, input string tag);
    modo    = v.modo;
    sel     = v.sel;
    valid_i = v.vin;
    d       = v.dd;
    ready_i = v.rdy;
    #1;
    check({tag, " ready_o"}, {28'd0, ready_o}, {28'd0, v.exp_ro});
    @(posedge clk);
    #1;
    check({tag, " q"},       {24'd0, q},       {24'd0, v.exp_q});
    check({tag, " canal_o"}, {30'd0, canal_o}, {30'd0, v.exp_c});
    check({tag, " valid_o"}, {31'd0, valid_o}, {31'd0, v.exp_v});
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, " q"},       {24'd0, q},       32'd0);
    check({tag, " canal_o"}, {30'd0, canal_o}, 32'd0);
    check({tag, " valid_o"}, {31'd0, valid_o}, 32'd0);
    check({tag, " ready_o"}, {28'd0, ready_o}, 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t v;

    //            modo  sel   vin      d             rdy   ro       q      c     v
    // fixed select
    vecs[0]  = '{1'b0, 2'd2, 4'b0101, 32'hA303A1A0, 1'b1, 4'b0100, 8'h03, 2'd2, 1'b1};
    vecs[1]  = '{1'b0, 2'd1, 4'b0101, 32'hA303A1A0, 1'b1, 4'b0000, 8'h03, 2'd2, 1'b0};
    vecs[2]  = '{1'b0, 2'd0, 4'b0101, 32'hA303A1A0, 1'b1, 4'b0001, 8'hA0, 2'd0, 1'b1};
    vecs[3]  = '{1'b0, 2'd0, 4'b0101, 32'hA303A1A0, 1'b0, 4'b0000, 8'hA0, 2'd0, 1'b1};
    vecs[4]  = '{1'b0, 2'd3, 4'b1000, 32'hA303A1A0, 1'b1, 4'b1000, 8'hA3, 2'd3, 1'b1};
    // round robin, all valid, with a 3-cycle stall after 0x11
    vecs[5]  = '{1'b1, 2'd0, 4'b1111, 32'h13121110, 1'b1, 4'b0001, 8'h10, 2'd0, 1'b1};
    vecs[6]  = '{1'b1, 2'd0, 4'b1111, 32'h13121110, 1'b1, 4'b0010, 8'h11, 2'd1, 1'b1};
    vecs[7]  = '{1'b1, 2'd0, 4'b1111, 32'h13121110, 1'b0, 4'b0000, 8'h11, 2'd1, 1'b1};
    vecs[8]  = '{1'b1, 2'd0, 4'b1111, 32'h13121110, 1'b0, 4'b0000, 8'h11, 2'd1, 1'b1};
    vecs[9]  = '{1'b1, 2'd0, 4'b1111, 32'h13121110, 1'b0, 4'b0000, 8'h11, 2'd1, 1'b1};
    vecs[10] = '{1'b1, 2'd0, 4'b1111, 32'h13121110, 1'b1, 4'b0100, 8'h12, 2'd2, 1'b1};
    vecs[11] = '{1'b1, 2'd0, 4'b1111, 32'h13121110, 1'b1, 4'b1000, 8'h13, 2'd3, 1'b1};
    vecs[12] = '{1'b1, 2'd0, 4'b1111, 32'h13121110, 1'b1, 4'b0001, 8'h10, 2'd0, 1'b1};
    vecs[13] = '{1'b1, 2'd0, 4'b1111, 32'h13121110, 1'b1, 4'b0010, 8'h11, 2'd1, 1'b1};
    // sparse round robin from ptr=2, then ch2 joins
    vecs[14] = '{1'b1, 2'd0, 4'b1010, 32'h13121110, 1'b1, 4'b1000, 8'h13, 2'd3, 1'b1};
    vecs[15] = '{1'b1, 2'd0, 4'b1010, 32'h13121110, 1'b1, 4'b0010, 8'h11, 2'd1, 1'b1};
    vecs[16] = '{1'b1, 2'd0, 4'b1010, 32'h13121110, 1'b1, 4'b1000, 8'h13, 2'd3, 1'b1};
    vecs[17] = '{1'b1, 2'd0, 4'b1110, 32'h13121110, 1'b1, 4'b0010, 8'h11, 2'd1, 1'b1};
    vecs[18] = '{1'b1, 2'd0, 4'b1110, 32'h13121110, 1'b1, 4'b0100, 8'h12, 2'd2, 1'b1};
    vecs[19] = '{1'b1, 2'd0, 4'b1110, 32'h13121110, 1'b1, 4'b1000, 8'h13, 2'd3, 1'b1};
    // idle drains, then a fixed-mode transfer must leave ptr at 0
    vecs[20] = '{1'b1, 2'd0, 4'b0000, 32'h13121110, 1'b1, 4'b0000, 8'h13, 2'd3, 1'b0};
    vecs[21] = '{1'b0, 2'd1, 4'b1111, 32'h13121110, 1'b1, 4'b0010, 8'h11, 2'd1, 1'b1};
    vecs[22] = '{1'b1, 2'd0, 4'b1111, 32'h13121110, 1'b1, 4'b0001, 8'h10, 2'd0, 1'b1};

    // Reset must act before any clock edge and hold ready_o low.
    rst_n   = 1'b1;
    modo    = 1'b1;
    sel     = '0;
    d       = 32'h13121110;
    valid_i = 4'hF;
    ready_i = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    check_reset_state("reset async");
    @(posedge clk);
    #1;
    check_reset_state("reset held");
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    for (int i = 0; i < 23; i++) begin
      apply_vec(vecs[i], $sformatf("vec%0d", i));
    end

    // Fixed-mode sweep of channel 0 across the full byte range and the wrap.
    for (int i = 0; i <= 256; i++) begin
      v = '{1'b0, 2'd0, 4'b0001, {24'd0, 8'(i)}, 1'b1, 4'b0001, 8'(i), 2'd0, 1'b1};
      apply_vec(v, $sformatf("sweep%0d", i));
    end

    // Burst with ptr left at 1, cut by reset mid-cycle.
    for (int i = 0; i < 8; i++) begin
      v = '{1'b0, 2'd0, 4'b0001, {24'd0, 8'(8'h40 + i)}, 1'b1, 4'b0001, 8'(8'h40 + i), 2'd0, 1'b1};
      apply_vec(v, $sformatf("burst%0d", i));
    end
    #2 rst_n = 1'b0;
    #1;
    check_reset_state("reset midburst");
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    v = '{1'b1, 2'd0, 4'b1111, 32'h13121110, 1'b1, 4'b0001, 8'h10, 2'd0, 1'b1};
    apply_vec(v, "post reset rr");
    v = '{1'b1, 2'd0, 4'b1111, 32'h13121110, 1'b1, 4'b0010, 8'h11, 2'd1, 1'b1};
    apply_vec(v, "post reset rr next");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
